// File: rtl/k005291_vram_arbiter.sv
// CPU/graphics arbiter for the K005291 scroll RAM, VRAM1 and VRAM2 ports.
// The tilemap fetch owns sub-slots 0-2; the CPU gets a 2-cycle window at P_SLOT_START.
module k005291_vram_arbiter #(
  parameter int P_SUBSLOTS   = 6,
  parameter int P_SLOT_START = 3
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_EMU_RST,
  input  logic       i_EMU_6MPOSCEN_n,
  input  logic       i_VZCS_n,
  input  logic       i_VCS1_n,
  input  logic       i_VCS2_n,
  input  logic       i_CPURW,
  input  logic       i_CPUUDS_n,
  input  logic       i_CPULDS_n,
  output logic       o_RAM_CPUSEL,
  output logic       o_SCROLLRAM_WE_n,
  output logic [1:0] o_VRAM1_WE_n,
  output logic       o_VRAM2_WE_n,
  output logic       o_RDLATCH_EN,
  output logic       o_CPU_DTACK_n,
  output logic       o_BUSY
);

  localparam logic [2:0] LP_LAST  = 3'(P_SUBSLOTS - 1);
  localparam logic [2:0] LP_START = 3'(P_SLOT_START);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS0, ST_ACCESS1, ST_DONE} state_t;
  typedef enum logic [1:0] {TGT_SCROLL, TGT_VRAM1, TGT_VRAM2} target_t;

  logic [2:0] r_s;
  logic [2:0] w_s_next;
  logic       r_req_q;
  logic       w_req;
  state_t     r_state;
  state_t     w_state_next;
  target_t    r_tgt;
  target_t    w_tgt;
  logic       w_latch;
  logic       r_rw;
  logic       r_uds;
  logic       r_lds;

  logic       r_cpusel,    w_cpusel;
  logic       r_scroll_we_n, w_scroll_we_n;
  logic [1:0] r_vram1_we_n,  w_vram1_we_n;
  logic       r_vram2_we_n,  w_vram2_we_n;
  logic       r_rdlatch,   w_rdlatch;
  logic       r_dtack_n,   w_dtack_n;
  logic       r_busy,      w_busy;

  // Sub-slot counter saturates so a missing pixel enable never opens a CPU window.
  always_comb begin
    if (!i_EMU_6MPOSCEN_n)    w_s_next = '0;
    else if (r_s >= LP_LAST)  w_s_next = LP_LAST;
    else                      w_s_next = r_s + 3'd1;
  end

  assign w_req = (~i_VZCS_n | ~i_VCS1_n | ~i_VCS2_n) & (~i_CPUUDS_n | ~i_CPULDS_n);

  always_comb begin
    if (!i_VZCS_n)      w_tgt = TGT_SCROLL;
    else if (!i_VCS1_n) w_tgt = TGT_VRAM1;
    else                w_tgt = TGT_VRAM2;
  end

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE:    if (r_req_q) w_state_next = ST_WAIT;
      ST_WAIT: begin
        // Decide on the upcoming sub-slot so ACCESS0 coincides with s == P_SLOT_START.
        if (!r_req_q) begin
          w_state_next = ST_IDLE;
        end else if (w_s_next == LP_START) begin
          w_state_next = ST_ACCESS0;
          w_latch      = 1'b1;
        end
      end
      ST_ACCESS0: w_state_next = ST_ACCESS1;
      ST_ACCESS1: w_state_next = ST_DONE;
      ST_DONE:    if (!r_req_q) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase

    w_cpusel      = (w_state_next == ST_ACCESS0) || (w_state_next == ST_ACCESS1);
    w_busy        = w_cpusel || (w_state_next == ST_WAIT);
    w_scroll_we_n = 1'b1;
    w_vram1_we_n  = 2'b11;
    w_vram2_we_n  = 1'b1;
    w_rdlatch     = 1'b0;
    if (w_state_next == ST_ACCESS1) begin
      if (r_rw) begin
        w_rdlatch = 1'b1;
      end else begin
        case (r_tgt)
          TGT_SCROLL: w_scroll_we_n = ~r_lds;
          TGT_VRAM1:  w_vram1_we_n  = {~r_uds, ~r_lds};
          default:    w_vram2_we_n  = ~r_lds;
        endcase
      end
    end
    // w_req is what r_req_q will hold during DONE, so DTACK tracks the live request.
    w_dtack_n = ~((w_state_next == ST_DONE) && w_req);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      r_s           <= '0;
      r_req_q       <= 1'b0;
      r_state       <= ST_IDLE;
      r_tgt         <= TGT_SCROLL;
      r_rw          <= 1'b1;
      r_uds         <= 1'b0;
      r_lds         <= 1'b0;
      r_cpusel      <= 1'b0;
      r_scroll_we_n <= 1'b1;
      r_vram1_we_n  <= 2'b11;
      r_vram2_we_n  <= 1'b1;
      r_rdlatch     <= 1'b0;
      r_dtack_n     <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_s           <= w_s_next;
      r_req_q       <= w_req;
      r_state       <= w_state_next;
      if (w_latch) begin
        r_tgt <= w_tgt;
        r_rw  <= i_CPURW;
        r_uds <= ~i_CPUUDS_n;
        r_lds <= ~i_CPULDS_n;
      end
      r_cpusel      <= w_cpusel;
      r_scroll_we_n <= w_scroll_we_n;
      r_vram1_we_n  <= w_vram1_we_n;
      r_vram2_we_n  <= w_vram2_we_n;
      r_rdlatch     <= w_rdlatch;
      r_dtack_n     <= w_dtack_n;
      r_busy        <= w_busy;
    end
  end

  assign o_RAM_CPUSEL     = r_cpusel;
  assign o_SCROLLRAM_WE_n = r_scroll_we_n;
  assign o_VRAM1_WE_n     = r_vram1_we_n;
  assign o_VRAM2_WE_n     = r_vram2_we_n;
  assign o_RDLATCH_EN     = r_rdlatch;
  assign o_CPU_DTACK_n    = r_dtack_n;
  assign o_BUSY           = r_busy;

endmodule

// File: tb/tb_k005291_vram_arbiter.sv
// Bench for k005291_vram_arbiter: timeline model built from input history, checked every cycle,
// plus directed scenarios with hand-computed latencies and strobe counts.
`timescale 1ns/1ps
module tb_k005291_vram_arbiter;

  localparam int LAST  = 5;
  localparam int START = 3;
  localparam int MAXC  = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen_n = 1'b1;
  logic       zcs_n = 1'b1, cs1_n = 1'b1, cs2_n = 1'b1;
  logic       rw = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic       stall = 1'b0;

  logic       o_sel, o_swe, o_v2we, o_rdl, o_dtack_n, o_busy;
  logic [1:0] o_v1we;

  int n_checks = 0;
  int n_fail   = 0;

  k005291_vram_arbiter dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_RST        (rst),
    .i_EMU_6MPOSCEN_n (pcen_n),
    .i_VZCS_n         (zcs_n),
    .i_VCS1_n         (cs1_n),
    .i_VCS2_n         (cs2_n),
    .i_CPURW          (rw),
    .i_CPUUDS_n       (uds_n),
    .i_CPULDS_n       (lds_n),
    .o_RAM_CPUSEL     (o_sel),
    .o_SCROLLRAM_WE_n (o_swe),
    .o_VRAM1_WE_n     (o_v1we),
    .o_VRAM2_WE_n     (o_v2we),
    .o_RDLATCH_EN     (o_rdl),
    .o_CPU_DTACK_n    (o_dtack_n),
    .o_BUSY           (o_busy)
  );

  initial forever #5 clk = ~clk;

  // Input history per cycle, and the sub-slot value each cycle must have.
  int cyc = 0;
  bit req_h [MAXC];
  bit rst_h [MAXC];
  bit rw_h  [MAXC];
  bit zcs_h [MAXC];
  bit cs1_h [MAXC];
  bit uds_h [MAXC];
  bit lds_h [MAXC];
  int s_h   [MAXC] = '{default: 0};

  always @(posedge clk) begin
    if (cyc < MAXC - 1) begin
      req_h[cyc] <= (!zcs_n || !cs1_n || !cs2_n) && (!uds_n || !lds_n);
      rst_h[cyc] <= rst;
      rw_h[cyc]  <= rw;
      zcs_h[cyc] <= zcs_n;
      cs1_h[cyc] <= cs1_n;
      uds_h[cyc] <= uds_n;
      lds_h[cyc] <= lds_n;
      s_h[cyc+1] <= (rst || !pcen_n) ? 0 : ((s_h[cyc] >= LAST) ? LAST : s_h[cyc] + 1);
      cyc        <= cyc + 1;
    end
  end

  // Pixel enable: one cycle low at the last sub-slot unless stalled.
  initial forever begin
    @(posedge clk);
    #1;
    pcen_n = stall || (s_h[cyc] != LAST);
  end

  typedef struct packed {
    logic       sel;
    logic       swe;
    logic [1:0] v1we;
    logic       v2we;
    logic       rdl;
    logic       dtack_n;
    logic       busy;
  } outs_t;

  // Expected outputs of cycle c from the request run that covers it: the run starts at t0,
  // waits from t0+2, is granted at the first later cycle whose sub-slot is START (if the
  // request is still held two cycles before), accesses for two cycles, then acks while held.
  function automatic outs_t model_at(input int c);
    outs_t e;
    int    r, t0, t1, a, l;
    bit    ended;
    e = '{sel: 1'b0, swe: 1'b1, v1we: 2'b11, v2we: 1'b1, rdl: 1'b0, dtack_n: 1'b1, busy: 1'b0};
    if (rst_h[c-1]) return e;
    r = 0;
    for (int x = 0; x < c; x++) if (rst_h[x]) r = x;
    t0 = -1;
    for (int x = r + 1; x <= c - 2; x++)
      if (req_h[x] && (x == r + 1 || !req_h[x-1])) t0 = x;
    if (t0 < 0) return e;
    t1 = c - 1;
    ended = 1'b0;
    for (int x = t0 + 1; x <= c - 1 && !ended; x++)
      if (!req_h[x]) begin t1 = x - 1; ended = 1'b1; end
    a = -1;
    for (int x = t0 + 3; x <= c && a < 0; x++)
      if (s_h[x] == START) a = x;
    if (a >= 0 && t1 >= a - 2) begin
      e.sel     = (c == a) || (c == a + 1);
      e.busy    = (c <= a + 1);
      e.dtack_n = !(c >= a + 2 && c <= t1 + 1);
      if (c == a + 1) begin
        l = a - 1;
        if (rw_h[l])       e.rdl  = 1'b1;
        else if (!zcs_h[l]) e.swe  = lds_h[l];
        else if (!cs1_h[l]) e.v1we = {uds_h[l], lds_h[l]};
        else                e.v2we = lds_h[l];
      end
    end else begin
      e.busy = !ended || (c <= t1 + 2);
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, required one (cycle %0d)", name, cyc);
  endtask

  // Monitor tallies used by the directed scenarios.
  int sel_cnt = 0, swe_cnt = 0, v1_cnt = 0, v2_cnt = 0, rdl_cnt = 0, dt_cnt = 0;
  logic [1:0] v1_last = 2'b11;

  initial forever begin
    outs_t e;
    @(negedge clk);
    if (cyc >= 1 && cyc < MAXC - 1) begin
      e = model_at(cyc);
      check("cpusel",   int'(o_sel),     int'(e.sel));
      check("scroll_we", int'(o_swe),    int'(e.swe));
      check("vram1_we", int'(o_v1we),    int'(e.v1we));
      check("vram2_we", int'(o_v2we),    int'(e.v2we));
      check("rdlatch",  int'(o_rdl),     int'(e.rdl));
      check("dtack_n",  int'(o_dtack_n), int'(e.dtack_n));
      check("busy",     int'(o_busy),    int'(e.busy));
      sel_cnt += int'(o_sel);
      if (!o_swe) swe_cnt++;
      if (o_v1we != 2'b11) begin v1_cnt++; v1_last = o_v1we; end
      if (!o_v2we) v2_cnt++;
      if (o_rdl) rdl_cnt++;
      if (!o_dtack_n) dt_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle_bus();
    zcs_n = 1'b1; cs1_n = 1'b1; cs2_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
  endtask

  task automatic wait_s(input int v);
    int k = 0;
    do begin tick(1); k++; end while (s_h[cyc] != v && k < 60);
    if (s_h[cyc] != v) expire("wait_subslot");
  endtask

  task automatic wait_dtack(input int t, input string name, input int exp_lat);
    int lat = -1;
    for (int k = 0; k < 30 && lat < 0; k++) begin
      @(negedge clk);
      if (!o_dtack_n) lat = cyc - t;
    end
    if (lat < 0) expire(name);
    else check(name, lat, exp_lat);
  endtask

  initial begin
    int t, p, f;
    int sel0, swe0, v10, v20, rdl0, dt0;

    // Reset held 3 cycles with a live VRAM1 request.
    cs1_n = 1'b0; lds_n = 1'b0;
    tick(2);
    @(negedge clk);
    check("rst_dtack",  int'(o_dtack_n), 1);
    check("rst_cpusel", int'(o_sel),     0);
    check("rst_vram1",  int'(o_v1we),    3);
    check("rst_busy",   int'(o_busy),    0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();
    tick(8);

    // VRAM1 upper-byte write arriving at s=4: grant at s=3 of next period, ack at s=5.
    wait_s(4);
    t = cyc; sel0 = sel_cnt; v10 = v1_cnt; rdl0 = rdl_cnt;
    cs1_n = 1'b0; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b1;
    wait_dtack(t, "v1w_latency", 7);
    check("v1w_sel_cycles", sel_cnt - sel0, 2);
    check("v1w_we_pulses",  v1_cnt - v10,   1);
    check("v1w_we_value",   int'(v1_last),  1);
    check("v1w_no_rdlatch", rdl_cnt - rdl0, 0);
    tick(2);
    idle_bus();
    tick(3);
    @(negedge clk);
    check("v1w_dtack_released", int'(o_dtack_n), 1);
    tick(4);

    // Scroll RAM read at s=0.
    wait_s(0);
    t = cyc; rdl0 = rdl_cnt; swe0 = swe_cnt;
    zcs_n = 1'b0; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    wait_dtack(t, "sread_latency", 5);
    check("sread_rdlatch", rdl_cnt - rdl0, 1);
    check("sread_no_we",   swe_cnt - swe0, 0);
    tick(1);
    idle_bus();
    tick(4);

    // VZCS and VCS2 together on a write: only scroll RAM strobed.
    wait_s(0);
    t = cyc; swe0 = swe_cnt; v20 = v2_cnt;
    zcs_n = 1'b0; cs2_n = 1'b0; rw = 1'b0; uds_n = 1'b1; lds_n = 1'b0;
    wait_dtack(t, "prio_latency", 5);
    check("prio_scroll_we", swe_cnt - swe0, 1);
    check("prio_vram2_we",  v2_cnt - v20,   0);
    tick(1);
    idle_bus();
    tick(4);

    // Abort while waiting for the window.
    wait_s(4);
    sel0 = sel_cnt; v20 = v2_cnt; dt0 = dt_cnt;
    cs2_n = 1'b0; rw = 1'b0; lds_n = 1'b0;
    tick(2);
    idle_bus();
    tick(10);
    check("abort_wait_sel",   sel_cnt - sel0, 0);
    check("abort_wait_we",    v2_cnt - v20,   0);
    check("abort_wait_dtack", dt_cnt - dt0,   0);
    @(negedge clk);
    check("abort_wait_busy", int'(o_busy), 0);
    tick(2);

    // Abort during ACCESS0: the write still lands, no DTACK.
    wait_s(0);
    sel0 = sel_cnt; v20 = v2_cnt; dt0 = dt_cnt;
    cs2_n = 1'b0; rw = 1'b0; lds_n = 1'b0;
    tick(3);
    idle_bus();
    tick(8);
    check("abort_acc_we",    v2_cnt - v20,   1);
    check("abort_acc_sel",   sel_cnt - sel0, 2);
    check("abort_acc_dtack", dt_cnt - dt0,   0);

    // Back-to-back: second request one cycle after release at s=1 waits for the next window.
    wait_s(0);
    t = cyc;
    cs1_n = 1'b0; rw = 1'b1; lds_n = 1'b0;
    wait_dtack(t, "b2b_first_latency", 5);
    tick(1);
    idle_bus();
    tick(1);
    t = cyc;
    cs1_n = 1'b0; rw = 1'b1; lds_n = 1'b0;
    wait_dtack(t, "b2b_second_latency", 10);
    tick(1);
    idle_bus();
    tick(4);

    // Pixel enable stalled with a pending request.
    wait_s(1);
    stall = 1'b1;
    tick(6);
    check("stall_subslot_saturates", s_h[cyc], 5);
    sel0 = sel_cnt;
    cs1_n = 1'b0; rw = 1'b1; lds_n = 1'b0;
    tick(20);
    check("stall_no_grant", sel_cnt - sel0, 0);
    @(negedge clk);
    stall = 1'b0;
    p = cyc + 1;
    f = -1;
    for (int k = 0; k < 20 && f < 0; k++) begin
      @(negedge clk);
      if (o_sel) f = cyc - p;
    end
    if (f < 0) expire("stall_grant");
    else check("stall_grant_offset", f, 4);
    wait_dtack(p, "stall_dtack", 6);
    tick(1);
    idle_bus();
    tick(4);

    // Reset during ACCESS1 cuts the strobe on the next cycle; the held request restarts.
    wait_s(0);
    cs1_n = 1'b0; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    tick(4);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_strobe_issued", int'(o_v1we), 0);
    tick(1);
    rst = 1'b0;
    t = cyc;
    @(negedge clk);
    check("rstmid_strobe_cut", int'(o_v1we), 3);
    check("rstmid_sel",        int'(o_sel),  0);
    check("rstmid_busy",       int'(o_busy), 0);
    wait_dtack(t, "rstmid_restart_latency", 5);
    tick(1);
    idle_bus();
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
